// File: rtl/text_overlay_pkg.sv
// Shared constants, types and helpers for the text overlay and its BCD converter.
package text_overlay_pkg;

  localparam int SCORE_LEN = 10;
  localparam int MSG_LEN   = 13;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  // Trailing four score characters are replaced by live digits.
  localparam logic [7:0] SCORE_STR [SCORE_LEN] = '{
    8'h53, 8'h43, 8'h4F, 8'h52, 8'h45, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h30
  };

  localparam logic [7:0] MSG_STR [MSG_LEN] = '{
    8'h50, 8'h52, 8'h45, 8'h53, 8'h53, 8'h20, 8'h41, 8'h4E, 8'h59, 8'h20,
    8'h4B, 8'h45, 8'h59
  };

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} bcd_state_t;

  function automatic logic [13:0] sat_score(input logic [13:0] s);
    logic [13:0] r;
    if (s > SCORE_MAX) r = SCORE_MAX;
    else r = s;
    return r;
  endfunction

  // Double-dabble correction: every nibble above 4 gets +3 before the shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] > 4'd4) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      else r[i*4 +: 4] = b[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/text_overlay_bin2bcd_seq.sv
// Iterative 14-bit binary to 4-digit BCD converter, one shift per clock.
module bin2bcd_seq
  import text_overlay_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  logic [13:0] bin_r;
  logic [15:0] bcd_r;
  logic [15:0] adj_s;
  logic [3:0]  cnt_r;
  logic        busy_r;
  logic        done_r;

  assign adj_s = bcd_adjust(bcd_r);

  // Load on start, then 14 add-3/shift iterations; done pulses after the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_r  <= 14'd0;
      bcd_r  <= 16'd0;
      cnt_r  <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start && !busy_r) begin
      bin_r  <= bin;
      bcd_r  <= 16'd0;
      cnt_r  <= 4'd0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      bcd_r <= {adj_s[14:0], bin_r[13]};
      bin_r <= {bin_r[12:0], 1'b0};
      cnt_r <= cnt_r + 4'd1;
      if (cnt_r == 4'd13) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;

endmodule

// File: rtl/text_overlay.sv
// Score/message text overlay: drives the font ROM address and produces a 2-clock-latency pixel mask.
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int SCORE_X    = 8,
  parameter int SCORE_Y    = 8,
  parameter int MSG_X      = 216,
  parameter int MSG_Y      = 232,
  parameter int SCALE_LOG2 = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic [13:0] score,
  input  logic        msg_en,
  output logic [7:0]  char_addr,
  output logic [2:0]  row_addr,
  input  logic [7:0]  bitmap,
  output logic        text_on,
  output logic        text_valid,
  output logic        bcd_busy
);

  localparam int CS = 8 << SCALE_LOG2;

  localparam logic [10:0] SX0 = 11'(SCORE_X);
  localparam logic [10:0] SX1 = 11'(SCORE_X + SCORE_LEN * CS);
  localparam logic [10:0] SY0 = 11'(SCORE_Y);
  localparam logic [10:0] SY1 = 11'(SCORE_Y + CS);
  localparam logic [10:0] MX0 = 11'(MSG_X);
  localparam logic [10:0] MX1 = 11'(MSG_X + MSG_LEN * CS);
  localparam logic [10:0] MY0 = 11'(MSG_Y);
  localparam logic [10:0] MY1 = 11'(MSG_Y + CS);

  logic [10:0] h_s, v_s, ox_s, oy_s, dx_s, dy_s;
  logic        sc_hit_s, msg_hit_s;
  logic [3:0]  idx_s, nib_s;
  logic [2:0]  col_s, grow_s;
  logic [7:0]  char_s;
  logic [2:0]  row_s, bit_s;
  logic        hit_s;

  logic [2:0]  bit_r;
  logic        region_r;
  logic        valid_r;

  bcd_state_t  state_r, next_s;
  logic [13:0] sat_s, cap_r, last_r;
  logic [15:0] digits_r, conv_bcd_s;
  logic        start_s, conv_busy_s, conv_done_s;

  assign h_s = {1'b0, hcount};
  assign v_s = {1'b0, vcount};

  assign sc_hit_s  = (h_s >= SX0) && (h_s < SX1) && (v_s >= SY0) && (v_s < SY1);
  assign msg_hit_s = msg_en && (h_s >= MX0) && (h_s < MX1) && (v_s >= MY0) && (v_s < MY1);

  // Cell-relative coordinates; the score origin wins where both regions overlap.
  always_comb begin
    ox_s = SX0;
    oy_s = SY0;
    if (sc_hit_s) begin
      ox_s = SX0;
      oy_s = SY0;
    end else begin
      ox_s = MX0;
      oy_s = MY0;
    end
    dx_s = h_s - ox_s;
    dy_s = v_s - oy_s;
  end

  assign idx_s  = 4'(dx_s >> (3 + SCALE_LOG2));
  assign col_s  = 3'(dx_s >> SCALE_LOG2);
  assign grow_s = 3'(dy_s >> SCALE_LOG2);

  // Character, glyph row and bit selection for the current pixel.
  always_comb begin
    char_s = ASCII_SPACE;
    row_s  = 3'd0;
    bit_s  = 3'd0;
    hit_s  = 1'b0;
    case (idx_s)
      4'd6:    nib_s = digits_r[15:12];
      4'd7:    nib_s = digits_r[11:8];
      4'd8:    nib_s = digits_r[7:4];
      default: nib_s = digits_r[3:0];
    endcase
    if (sc_hit_s) begin
      hit_s = 1'b1;
      row_s = grow_s;
      bit_s = 3'd7 - col_s;
      if (idx_s < 4'd6) char_s = SCORE_STR[idx_s];
      else char_s = ASCII_ZERO + {4'd0, nib_s};
    end else if (msg_hit_s) begin
      hit_s  = 1'b1;
      row_s  = grow_s;
      bit_s  = 3'd7 - col_s;
      char_s = MSG_STR[idx_s];
    end else begin
      hit_s  = 1'b0;
      char_s = ASCII_SPACE;
    end
  end

  // Stage 1: ROM address plus the bit index and region flag that travel with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_addr <= ASCII_SPACE;
      row_addr  <= 3'd0;
      bit_r     <= 3'd0;
      region_r  <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      char_addr <= char_s;
      row_addr  <= row_s;
      bit_r     <= bit_s;
      region_r  <= hit_s;
      valid_r   <= pix_valid;
    end
  end

  // Stage 2: pick the glyph bit returned by the ROM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      text_on    <= 1'b0;
      text_valid <= 1'b0;
    end else begin
      text_on    <= region_r & valid_r & bitmap[bit_r];
      text_valid <= valid_r;
    end
  end

  assign sat_s   = sat_score(score);
  assign start_s = (state_r == IDLE) && frame_start && !conv_busy_s && (sat_s != last_r);

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .bin   (sat_s),
    .busy  (conv_busy_s),
    .done  (conv_done_s),
    .bcd   (conv_bcd_s)
  );

  // BCD sequencing: start in IDLE, wait out the shifts, publish digits in LATCH.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    if (start_s) next_s = SHIFT; else next_s = IDLE;
      SHIFT:   if (conv_done_s) next_s = LATCH; else next_s = SHIFT;
      LATCH:   next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Digits only move in LATCH, which always lands inside vertical blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      bcd_busy <= 1'b0;
      cap_r    <= 14'd0;
      last_r   <= 14'd0;
      digits_r <= 16'd0;
    end else begin
      state_r  <= next_s;
      bcd_busy <= (next_s != IDLE);
      if (start_s) cap_r <= sat_s;
      if (state_r == LATCH) begin
        digits_r <= conv_bcd_s;
        last_r   <= cap_r;
      end
    end
  end

endmodule

// File: tb/tb_text_overlay.sv
// Randomized self-checking bench for text_overlay against a behavioural screen/score model.
module tb_text_overlay;

  localparam int SX = 8;
  localparam int SY = 8;
  localparam int MX = 216;
  localparam int MY = 232;
  localparam int SL = 1;
  localparam int S  = 1 << SL;
  localparam int CS = 8 * S;

  typedef struct packed {
    logic [7:0] ch;
    logic [2:0] row;
    logic       on;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  hcount = 10'd0;
  logic [9:0]  vcount = 10'd0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [13:0] score = 14'd0;
  logic        msg_en = 1'b0;
  logic [7:0]  char_addr;
  logic [2:0]  row_addr;
  logic [7:0]  bitmap;
  logic        text_on;
  logic        text_valid;
  logic        bcd_busy;

  int total = 0;
  int bad = 0;

  logic [7:0] score_txt [6]  = '{8'h53, 8'h43, 8'h4F, 8'h52, 8'h45, 8'h3A};
  logic [7:0] msg_txt   [13] = '{8'h50, 8'h52, 8'h45, 8'h53, 8'h53, 8'h20, 8'h41,
                                 8'h4E, 8'h59, 8'h20, 8'h4B, 8'h45, 8'h59};

  always #5 clk = ~clk;

  text_overlay #(
    .SCORE_X(SX), .SCORE_Y(SY), .MSG_X(MX), .MSG_Y(MY), .SCALE_LOG2(SL)
  ) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .pix_valid(pix_valid), .frame_start(frame_start), .score(score),
    .msg_en(msg_en), .char_addr(char_addr), .row_addr(row_addr),
    .bitmap(bitmap), .text_on(text_on), .text_valid(text_valid),
    .bcd_busy(bcd_busy)
  );

  // Stand-in font ROM: two pinned glyph rows, pseudo-random elsewhere.
  function automatic logic [7:0] font(input logic [7:0] c, input logic [2:0] r);
    if (c == 8'h53 && r == 3'd0) return 8'h7C;
    else if (c == 8'h50 && r == 3'd1) return 8'hCC;
    else return 8'((int'(c) * 13 + int'(r) * 37) ^ 8'hA5);
  endfunction

  assign bitmap = font(char_addr, row_addr);

  function automatic int sat(input int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  function automatic pix_t pix_eval(input int h, input int v, input bit valid,
                                    input bit men, input int disp);
    pix_t p;
    int ox, oy, idx, col, k, pw;
    bit hit, is_score;
    logic [7:0] g;
    hit = 0; is_score = 0; ox = 0; oy = 0;
    if (h >= SX && h < SX + 10 * CS && v >= SY && v < SY + CS) begin
      hit = 1; is_score = 1; ox = SX; oy = SY;
    end else if (men && h >= MX && h < MX + 13 * CS && v >= MY && v < MY + CS) begin
      hit = 1; ox = MX; oy = MY;
    end
    p.ch = 8'h20; p.row = 3'd0; p.on = 1'b0;
    if (hit) begin
      idx = (h - ox) / CS;
      col = ((h - ox) / S) % 8;
      p.row = 3'(((v - oy) / S) % 8);
      if (is_score && idx < 6) p.ch = score_txt[idx];
      else if (is_score) begin
        k = idx - 6;
        pw = (k == 0) ? 1000 : (k == 1) ? 100 : (k == 2) ? 10 : 1;
        p.ch = 8'(48 + (disp / pw) % 10);
      end else p.ch = msg_txt[idx];
      g = font(p.ch, p.row);
      p.on = valid && g[7 - col];
    end
    return p;
  endfunction

  // Model state: displayed value, last converted value, busy countdown.
  int   m_disp, m_last, m_pend, m_busy;
  pix_t cur_pix;
  logic [7:0] e_ch;
  logic [2:0] e_row;
  logic e_on1, e_v1, e_on, e_tv;

  assign cur_pix = pix_eval(int'(hcount), int'(vcount), pix_valid, msg_en, m_disp);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_ch <= 8'h20; e_row <= 3'd0; e_on1 <= 1'b0; e_v1 <= 1'b0;
      e_on <= 1'b0; e_tv <= 1'b0;
      m_disp <= 0; m_last <= 0; m_pend <= 0; m_busy <= 0;
    end else begin
      e_ch <= cur_pix.ch; e_row <= cur_pix.row; e_on1 <= cur_pix.on; e_v1 <= pix_valid;
      e_on <= e_on1; e_tv <= e_v1;
      if (m_busy != 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_disp <= m_pend;
          m_last <= m_pend;
        end
      end else if (frame_start && sat(int'(score)) != m_last) begin
        m_busy <= 16;
        m_pend <= sat(int'(score));
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("char_addr", int'(char_addr), int'(e_ch));
    chk("row_addr", int'(row_addr), int'(e_row));
    chk("text_on", int'(text_on), int'(e_on));
    chk("text_valid", int'(text_valid), int'(e_tv));
    chk("bcd_busy", int'(bcd_busy), (m_busy != 0) ? 1 : 0);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic show_cell(input int idx);
    hcount = 10'(SX + idx * CS);
    vcount = 10'(SY);
    tick();
  endtask

  logic [15:0] got;
  int n;

  initial begin
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_char", int'(char_addr), 32);
    chk("rst_row", int'(row_addr), 0);
    chk("rst_on", int'(text_on), 0);
    chk("rst_valid", int'(text_valid), 0);
    chk("rst_busy", int'(bcd_busy), 0);

    // Row 0 of 'S', stretched 2x.
    vcount = 10'(SY); pix_valid = 1'b1; got = 16'd0;
    for (int i = 0; i < 18; i++) begin
      hcount = 10'(SX + i);
      tick();
      if (i == 0) chk("s_char", int'(char_addr), 8'h53);
      if (i >= 1 && i <= 16) got[16 - i] = text_on;
    end
    chk("s_row0", int'(got), 16'b0011_1111_1111_0000);
    show_cell(6);
    chk("zero_digit", int'(char_addr), 8'h30);

    score = 14'd1234;
    pulse_fs();
    n = (bcd_busy) ? 1 : 0;
    repeat (39) begin tick(); if (bcd_busy) n++; end
    chk("busy_len", n, 16);
    for (int k = 0; k < 4; k++) begin
      show_cell(6 + k);
      chk("d1234", int'(char_addr), 8'h31 + k);
    end

    score = 14'd12000;
    pulse_fs();
    repeat (20) tick();
    show_cell(9);
    chk("sat9999", int'(char_addr), 8'h39);
    score = 14'd9999;
    pulse_fs();
    n = (bcd_busy) ? 1 : 0;
    repeat (19) begin tick(); if (bcd_busy) n++; end
    chk("no_reconv", n, 0);

    score = 14'd1111;
    pulse_fs();
    repeat (3) tick();
    score = 14'd2222;
    pulse_fs();
    repeat (20) tick();
    show_cell(6);
    chk("ignored_fs", int'(char_addr), 8'h31);
    pulse_fs();
    repeat (20) tick();
    show_cell(6);
    chk("next_fs", int'(char_addr), 8'h32);

    // Message pixel, enabled and disabled, with the 2-cycle lag.
    for (int m = 1; m >= 0; m--) begin
      msg_en = 1'(m); pix_valid = 1'b0;
      hcount = 10'(MX); vcount = 10'(MY + 2);
      tick(); tick();
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      chk("lag_v1", int'(text_valid), 0);
      tick();
      chk("lag_v2", int'(text_valid), 1);
      chk("msg_on", int'(text_on), m);
      tick();
      chk("lag_v3", int'(text_valid), 0);
    end

    score = 14'd500;
    pulse_fs();
    hcount = 10'(SX + 7 * CS); vcount = 10'(SY); pix_valid = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_char", int'(char_addr), 32);
    chk("mid_rst_busy", int'(bcd_busy), 0);
    chk("mid_rst_on", int'(text_on), 0);
    reset = 1'b0;
    tick();
    chk("rst_digit", int'(char_addr), 8'h30);
    pulse_fs();
    repeat (20) tick();
    show_cell(7);
    chk("d0500", int'(char_addr), 8'h35);

    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 9);
      if (n < 4) begin
        hcount = 10'(SX - 2 + $urandom_range(0, 10 * CS + 4));
        vcount = 10'(SY - 2 + $urandom_range(0, CS + 4));
      end else if (n < 8) begin
        hcount = 10'(MX - 2 + $urandom_range(0, 13 * CS + 4));
        vcount = 10'(MY - 2 + $urandom_range(0, CS + 4));
      end else begin
        hcount = 10'($urandom_range(0, 1023));
        vcount = 10'($urandom_range(0, 1023));
      end
      pix_valid = ($urandom_range(0, 3) != 0);
      msg_en = 1'($urandom_range(0, 1));
      frame_start = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) score = 14'($urandom_range(0, 16383));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
